// File: rtl/cla_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial CLA add/subtract controller.
package cla_serial_adder_ctrl_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Nibble index width: clog2 of the slice count, never below one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_serial_adder_ctrl_if.sv
// Start/busy/done operation bus between the operand source and the controller.
interface cla_serial_adder_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  modport master (
    output start, op_sub, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, op_sub, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/cla_serial_adder_ctrl_cla4.sv
// Purely combinational 4-bit carry look-ahead adder slice.
module carry_look_ahead_adder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is formed directly from generate/propagate terms and c_in.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];
endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// Nibble-serial W-bit add/subtract built on one shared 4-bit CLA slice, LSB first.
module cla_serial_adder_ctrl
  import cla_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_serial_adder_ctrl_if.slave bus
);
  localparam int unsigned W     = NIB_W * NIBBLES;
  localparam int unsigned IDX_W = idx_width(NIBBLES);
  localparam int unsigned SH_W  = IDX_W + 2;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     sum_q;
  logic             c_out_q;
  logic             overflow_q;

  logic [SH_W-1:0]  shamt_c;
  logic [3:0]       slice_a_c;
  logic [3:0]       slice_b_c;
  logic [3:0]       slice_sum_c;
  logic             slice_co_c;

  // Nibble select: bit offset of the current slice within the operand.
  assign shamt_c   = {idx, 2'b00};
  assign slice_a_c = 4'(a_reg >> shamt_c);
  assign slice_b_c = 4'(b_reg >> shamt_c);

  carry_look_ahead_adder_4b u_slice (
    .a     (slice_a_c),
    .b     (slice_b_c),
    .c_in  (carry_reg),
    .sum   (slice_sum_c),
    .c_out (slice_co_c)
  );

  // Operation sequencer: latch operands, walk nibbles, then pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      carry_reg  <= 1'b0;
      idx        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
            carry_reg <= (bus.op_sub == OP_SUB) ? 1'b1 : bus.c_in;
            idx       <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q     <= (sum_q & ~(W'(4'hF) << shamt_c)) | (W'(slice_sum_c) << shamt_c);
          carry_reg <= slice_co_c;
          if (idx == IDX_W'(NIBBLES - 1)) begin
            c_out_q    <= slice_co_c;
            overflow_q <= (a_reg[W-1] ~^ b_reg[W-1]) & (slice_sum_c[3] ^ a_reg[W-1]);
            done_q     <= 1'b1;
            state      <= ST_DONE;
          end else begin
            idx <= IDX_W'(idx + 1'b1);
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = overflow_q;
endmodule
